// File: rtl/avmm_burst_rom_slave.sv
//------------------------------------------------------------------------------
// avmm_burst_rom_slave
//   Avalon-MM read-only burst slave in front of a DEPTH x DATA_W synchronous
//   ROM (for example, matrix rows for the compute datapath). An accepted
//   command waits DELAY+1 cycles, then streams one ROM word per cycle. The
//   address wraps modulo DEPTH. An address with any bit set above the ROM
//   index returns DECODEERROR beats with zero data, using the same beat count
//   and the same timing as an OKAY burst.
//
//   Ports
//     clk            clock
//     reset_n        asynchronous, active-low reset
//     address        word address (32 bits)
//     read           read request
//     burstcount     beats requested; 0 is treated as 1
//     readdata       returned word
//     readdatavalid  readdata/response valid this cycle
//     response       2'b00 OKAY, 2'b11 DECODEERROR
//     waitrequest    high = command not accepted (registered)
//     state          debug: IDLE=00 WAIT=01 STREAM=10 DRAIN=11
//
//   ROM image: every byte of word i equals i.
//
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module avmm_burst_rom_slave #(
    parameter int    DATA_W    = 64,
    parameter int    ADDR_W    = 3,
    parameter int    BURST_W   = 4,
    parameter int    DELAY     = 10,
    parameter string INIT_FILE = "rom_init.hex"
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        address,
    input  logic               read,
    input  logic [BURST_W-1:0] burstcount,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic [1:0]         response,
    output logic               waitrequest,
    output logic [1:0]         state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DLY_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_STREAM = 2'b10,
        S_DRAIN  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic               accept, issue;
    logic [ADDR_W-1:0]  addr_cur;
    logic               err;
    logic [BURST_W-1:0] beats_left;
    logic [DLY_W-1:0]   dly;
    logic               issue_v;
    logic [DATA_W-1:0]  rom_q;

    assign state = state_q;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read && !waitrequest) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dly == '0) state_d = S_STREAM;
            end
            S_STREAM: begin
                issue = 1'b1;
                if (beats_left == BURST_W'(1)) state_d = S_DRAIN;
            end
            // One cycle is enough for the last beat to leave the ROM stage. The
            // output register then presents it while the FSM is already back in
            // IDLE, so back-to-back commands are possible.
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Command registers, issue pipeline and output register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_cur      <= '0;
            err           <= 1'b0;
            beats_left    <= '0;
            dly           <= '0;
            issue_v       <= 1'b0;
            waitrequest   <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            response      <= 2'b00;
        end else begin
            if (accept) begin
                addr_cur   <= address[ADDR_W-1:0];
                err        <= |address[31:ADDR_W];
                beats_left <= (burstcount == '0) ? BURST_W'(1) : burstcount;
                dly        <= DLY_W'(DELAY);
            end else if (state_q == S_WAIT && dly != '0) begin
                dly <= dly - DLY_W'(1);
            end

            if (issue) begin
                addr_cur   <= addr_cur + ADDR_W'(1);  // natural wrap modulo DEPTH
                beats_left <= beats_left - BURST_W'(1);
            end

            issue_v     <= issue;
            waitrequest <= (state_d != S_IDLE);

            // readdata keeps its last value on idle cycles.
            readdatavalid <= issue_v;
            if (issue_v) begin
                readdata <= err ? '0 : rom_q;
                response <= err ? 2'b11 : 2'b00;
            end
        end
    end

    //--------------------------------------------------------------------------
    // ROM: registered address, one cycle of read latency
    //--------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] idx);
        logic [7:0]        b;
        logic [DATA_W-1:0] w;
        b = 8'(idx);
        w = '0;
        for (int i = 0; i < DATA_W; i++) w[i] = b[i % 8];
        return w;
    endfunction

    always_ff @(posedge clk) rom_q <= pattern(addr_cur);

endmodule

`default_nettype wire

// File: tb/tb_avmm_burst_rom_slave.sv
//------------------------------------------------------------------------------
// tb_avmm_burst_rom_slave
//   Two instances: DELAY=10 and DELAY=0. Each instance has its own driver and
//   its own monitor. The driver issues directed and random commands, injects
//   noise while waitrequest is high, and finishes with a mid-burst reset. Every
//   accepted command pushes its expected beats, with their exact arrival
//   edges, into a queue. The monitor pops one entry for each readdatavalid it
//   sees and compares the beat against it.
//------------------------------------------------------------------------------
`default_nettype none

module tb_avmm_burst_rom_slave;

  localparam int DEPTH = 8;
  localparam int NCMD  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  bit done [2];

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          edge_no;
    bit          last;
  } exp_t;

  function automatic logic [63:0] rom_word(int idx);
    logic [7:0] b;
    b = 8'(idx);
    return {8{b}};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = (gi == 0) ? 10 : 0;

    logic        reset_n, read, readdatavalid, waitrequest;
    logic [31:0] address;
    logic [3:0]  burstcount;
    logic [63:0] readdata;
    logic [1:0]  response, state;
    exp_t        q [$];
    exp_t        e;

    avmm_burst_rom_slave #(
      .DATA_W(64), .ADDR_W(3), .BURST_W(4), .DELAY(D), .INIT_FILE("")
    ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .read(read),
      .burstcount(burstcount), .readdata(readdata),
      .readdatavalid(readdatavalid), .response(response),
      .waitrequest(waitrequest), .state(state)
    );

    // Reference model: expand the command currently on the bus into beats.
    task automatic push_cmd(int a_edge);
      int n;
      bit er;
      n  = (burstcount == 0) ? 1 : int'(burstcount);
      er = (address[31:3] != 0);
      for (int k = 0; k < n; k++) begin
        exp_t x;
        x.data    = er ? 64'd0 : rom_word((int'(address[2:0]) + k) % DEPTH);
        x.resp    = er ? 2'b11 : 2'b00;
        x.edge_no = a_edge + D + 3 + k;
        x.last    = (k == n - 1);
        q.push_back(x);
      end
    endtask

    // Monitor
    always @(negedge clk) begin
      if (readdatavalid) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL i%0d unexpected_beat: got readdatavalid=1 at edge %0d, required no beat", gi, cyc);
        end else begin
          e = q.pop_front();
          check($sformatf("i%0d readdata", gi), readdata, e.data);
          check($sformatf("i%0d response", gi), 64'(response), 64'(e.resp));
          check($sformatf("i%0d beat_edge", gi), 64'(cyc), 64'(e.edge_no));
          if (e.last) begin
            check($sformatf("i%0d last_waitreq", gi), 64'(waitrequest), 64'd0);
            check($sformatf("i%0d last_state", gi), 64'(state), 64'd0);
          end else begin
            check($sformatf("i%0d mid_waitreq", gi), 64'(waitrequest), 64'd1);
          end
        end
      end
    end

    // Driver
    initial begin
      int a_edge, guard;
      logic [31:0] a;
      logic [3:0]  b;
      reset_n = 1'b0; read = 1'b0; address = '0; burstcount = '0;
      repeat (3) @(negedge clk);
      check($sformatf("i%0d rst_readdata", gi), readdata, 64'd0);
      check($sformatf("i%0d rst_valid", gi), 64'(readdatavalid), 64'd0);
      check($sformatf("i%0d rst_response", gi), 64'(response), 64'd0);
      check($sformatf("i%0d rst_waitreq", gi), 64'(waitrequest), 64'd0);
      check($sformatf("i%0d rst_state", gi), 64'(state), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int c = 0; c < NCMD; c++) begin
        case (c)
          0: begin a = 32'd3;  b = 4'd1; end
          1: begin a = 32'd6;  b = 4'd4; end
          2: begin a = 32'h10; b = 4'd2; end
          3: begin a = 32'd5;  b = 4'd0; end
          default: begin
            a = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFF8) | 32'h8 : 32'($urandom_range(0, 7));
            b = 4'($urandom_range(0, 15));
          end
        endcase
        guard = 0;
        while (waitrequest && guard < 300) begin
          read = 1'($urandom_range(0, 1));
          address = $urandom;
          burstcount = 4'($urandom);
          @(negedge clk);
          guard++;
        end
        if (guard >= 300) begin
          n_total++;
          $display("FAIL i%0d accept_timeout: got waitrequest=1 for 300 cycles, required release", gi);
          break;
        end
        if (c >= 4 && $urandom_range(0, 3) == 0) begin
          read = 1'b0;
          repeat (2) @(negedge clk);
        end
        read = 1'b1; address = a; burstcount = b;
        push_cmd(cyc + 1);
        @(negedge clk);
        read = 1'b0;
      end

      guard = 0;
      while (q.size() != 0 && guard < 400) begin @(negedge clk); guard++; end
      check($sformatf("i%0d drained", gi), 64'(q.size()), 64'd0);
      repeat (2) @(negedge clk);

      // Mid-burst reset during beat 2 of a 4-beat burst
      read = 1'b1; address = 32'd0; burstcount = 4'd4;
      a_edge = cyc + 1;
      push_cmd(a_edge);
      @(negedge clk);
      read = 1'b0;
      while (cyc < a_edge + D + 4) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check($sformatf("i%0d mrst_valid", gi), 64'(readdatavalid), 64'd0);
      check($sformatf("i%0d mrst_waitreq", gi), 64'(waitrequest), 64'd0);
      check($sformatf("i%0d mrst_state", gi), 64'(state), 64'd0);
      check($sformatf("i%0d mrst_readdata", gi), readdata, 64'd0);
      check($sformatf("i%0d beats_before_reset", gi), 64'(q.size()), 64'd2);
      q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (D + 10) @(negedge clk);

      // Recovery command after reset
      read = 1'b1; address = 32'd7; burstcount = 4'd2;
      push_cmd(cyc + 1);
      @(negedge clk);
      read = 1'b0;
      guard = 0;
      while (q.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
      check($sformatf("i%0d final_drained", gi), 64'(q.size()), 64'd0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1]) && t < 40000) begin @(posedge clk); t++; end
    if (!(done[0] && done[1])) begin
      n_total++;
      $display("FAIL global_timeout: got unfinished drivers, required completion");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
